fifo_rd_packer: RTL and testbench

//   Read-side consumer of the async FIFO, in the read clock domain. Pops IN_WIDTH-bit words through the

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_packer_oreg.sv | 51 +++++
 rtl/fifo_rd_packer.sv | 121 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO and its read-side consumers.
package fifo_pkg;

   localparam int FIFO_WIDTH = 4;
   localparam int RD_LAT     = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_rd_packer_oreg.sv
// Output holding register: keeps a beat stable on the stream until the sink accepts it.
module fifo_rd_packer_oreg #(
   parameter int OUT_WIDTH = 16,
   parameter int PACK      = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [OUT_WIDTH-1:0] i_data,
   input  logic [PACK-1:0]      i_keep,
   input  logic                 i_ready,
   output logic [OUT_WIDTH-1:0] o_tdata,
   output logic [PACK-1:0]      o_keep,
   output logic                 o_tvalid
);

   logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
   logic [PACK-1:0]      keep_q, keep_d;
   logic                 tvalid_q, tvalid_d;

   // A load is only requested when the register is free, so it may replace an accepted beat.
   always_comb begin
      tdata_d  = tdata_q;
      keep_d   = keep_q;
      tvalid_d = tvalid_q;
      if (i_load) begin
         tdata_d  = i_data;
         keep_d   = i_keep;
         tvalid_d = 1'b1;
      end else if (tvalid_q & i_ready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tdata_q  <= '0;
         keep_q   <= '0;
         tvalid_q <= 1'b0;
      end else begin
         tdata_q  <= tdata_d;
         keep_q   <= keep_d;
         tvalid_q <= tvalid_d;
      end
   end

   assign o_tdata  = tdata_q;
   assign o_keep   = keep_q;
   assign o_tvalid = tvalid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs PACK of them per output beat; a flush emits a partial beat with a keep mask.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int IN_WIDTH = FIFO_WIDTH,
   parameter int PACK     = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   output logic                     o_fifo_ren,
   input  logic [IN_WIDTH-1:0]      i_fifo_rdata,
   input  logic                     i_fifo_rempty,
   input  logic                     i_flush,
   output logic [IN_WIDTH*PACK-1:0] o_tdata,
   output logic [PACK-1:0]          o_keep,
   output logic                     o_tvalid,
   input  logic                     i_tready
);

   localparam int OUT_WIDTH = IN_WIDTH * PACK;
   localparam int CNT_W     = clog2(PACK + 1);
   localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);

   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RD_LAT-1:0]    ren_q, ren_d;
   logic                 flushPend_q, flushPend_d;

   logic                 inFlight;
   logic                 free;
   logic                 emit;
   logic                 pemit;
   logic                 fifoRen;
   logic [CNT_W-1:0]     baseCnt;
   logic [CNT_W:0]       pending;
   logic [PACK-1:0]      partKeep;
   logic [OUT_WIDTH-1:0] laneMask;
   logic [OUT_WIDTH-1:0] loadData;
   logic [PACK-1:0]      loadKeep;
   logic [OUT_WIDTH-1:0] oregData;
   logic [PACK-1:0]      oregKeep;
   logic                 oregValid;

   // Reads are issued only while lanes filled plus words in flight stay below PACK.
   always_comb begin
      inFlight = ren_q[RD_LAT-1];
      free     = ~oregValid | i_tready;
      emit     = (cnt_q == PACK_CNT) & free;
      pemit    = flushPend_q & ~inFlight & (cnt_q != '0) & (cnt_q != PACK_CNT) & free;
      baseCnt  = (emit | pemit) ? '0 : cnt_q;
      pending  = {1'b0, baseCnt} + (CNT_W + 1)'(inFlight);
      fifoRen  = ~i_rst & ~i_fifo_rempty & ~flushPend_q & (pending < (CNT_W + 1)'(PACK));
      for (int k = 0; k < PACK; k++) begin
         partKeep[k] = (CNT_W'(k) < cnt_q);
         laneMask[k*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{partKeep[k]}};
      end
      loadData = emit ? acc_q : (acc_q & laneMask);
      loadKeep = emit ? '1 : partKeep;
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ren_d       = RD_LAT'({ren_q, fifoRen});
      flushPend_d = flushPend_q;
      if (emit | pemit) begin
         cnt_d = '0;
      end
      if (inFlight) begin
         for (int k = 0; k < PACK; k++) begin
            if (cnt_q == CNT_W'(k)) begin
               acc_d[k*IN_WIDTH +: IN_WIDTH] = i_fifo_rdata;
            end
         end
         cnt_d = cnt_q + CNT_W'(1);
      end
      // A pending flush retires on any beat, or immediately when nothing is buffered.
      if (flushPend_q) begin
         if (emit | pemit | ((cnt_q == '0) & ~inFlight)) begin
            flushPend_d = 1'b0;
         end
      end else if (i_flush) begin
         flushPend_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         ren_q       <= '0;
         flushPend_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ren_q       <= ren_d;
         flushPend_q <= flushPend_d;
      end
   end

   fifo_rd_packer_oreg #(
      .OUT_WIDTH (OUT_WIDTH),
      .PACK      (PACK)
   ) u_oreg (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (emit | pemit),
      .i_data   (loadData),
      .i_keep   (loadKeep),
      .i_ready  (i_tready),
      .o_tdata  (oregData),
      .o_keep   (oregKeep),
      .o_tvalid (oregValid)
   );

   assign o_fifo_ren = fifoRen;
   assign o_tdata    = i_rst ? '0 : oregData;
   assign o_keep     = i_rst ? '0 : oregKeep;
   assign o_tvalid   = ~i_rst & oregValid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural one-cycle-latency FIFO and a beat monitor.
module tb_fifo_rd_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifoRen;
   logic [3:0]  fifoRdata = '0;
   logic        fifoRempty;
   logic        flush;
   logic [15:0] tdata;
   logic [3:0]  keep;
   logic        tvalid;
   logic        tready;

   logic [3:0]  fifoMem [0:63];
   int          wrPtr = 0;
   int          rdPtr = 0;

   logic [15:0] beatData [0:31];
   logic [3:0]  beatKeep [0:31];
   int          beatCount = 0;

   int          assertCount = 0;
   int          failCount = 0;

   always #5 clk = ~clk;

   fifo_rd_packer #(
      .IN_WIDTH (4),
      .PACK     (4)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_fifo_ren    (fifoRen),
      .i_fifo_rdata  (fifoRdata),
      .i_fifo_rempty (fifoRempty),
      .i_flush       (flush),
      .o_tdata       (tdata),
      .o_keep        (keep),
      .o_tvalid      (tvalid),
      .i_tready      (tready)
   );

   // FIFO model: data appears the cycle after a read is sampled on a non-empty FIFO.
   assign fifoRempty = (wrPtr == rdPtr);

   always @(posedge clk) begin
      if (fifoRen && !fifoRempty) begin
         fifoRdata <= fifoMem[rdPtr];
         rdPtr     <= rdPtr + 1;
      end
   end

   // Record every beat the sink accepts.
   always @(negedge clk) begin
      if (!rst && tvalid && tready) begin
         beatData[beatCount] <= tdata;
         beatKeep[beatCount] <= keep;
         beatCount           <= beatCount + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] word);
      fifoMem[wrPtr] = word;
      wrPtr = wrPtr + 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
      end
   endtask

   task automatic waitBeats(input int target, input string tag);
      int n;
      n = 0;
      while (beatCount < target && n < 100) begin
         step();
         n++;
      end
      checkOutput(tag, beatCount, target);
   endtask

   initial begin
      rst    = 1'b1;
      flush  = 1'b0;
      tready = 1'b1;
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      applyStimulus(4'h3);
      applyStimulus(4'h4);

      // Reset held with a non-empty FIFO: nothing may be read or emitted.
      for (int i = 0; i < 3; i++) begin
         step();
         settle();
         checkOutput("rst_ren", fifoRen, 1'b0);
         checkOutput("rst_tvalid", tvalid, 1'b0);
         checkOutput("rst_keep", keep, 4'h0);
      end

      // Full pack: first read in cycle 0, beat visible in cycle 6.
      step();
      rst = 1'b0;
      settle();
      checkOutput("full_ren_c0", fifoRen, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         step();
         settle();
         if (c == 5) checkOutput("full_tvalid_c5", tvalid, 1'b0);
         if (c == 6) begin
            checkOutput("full_tvalid_c6", tvalid, 1'b1);
            checkOutput("full_tdata_c6", tdata, 16'h4321);
            checkOutput("full_keep_c6", keep, 4'hF);
         end
      end
      step();
      settle();
      checkOutput("full_tvalid_c7", tvalid, 1'b0);
      checkOutput("full_beats", beatCount, 1);
      checkOutput("full_beat0", beatData[0], 16'h4321);

      // Backpressure: first beat held, second pack waits in the accumulator.
      step();
      tready = 1'b0;
      for (int w = 1; w <= 8; w++) begin
         applyStimulus(4'(w));
      end
      waitCycles(20);
      settle();
      checkOutput("bp_tvalid", tvalid, 1'b1);
      checkOutput("bp_tdata", tdata, 16'h4321);
      checkOutput("bp_keep", keep, 4'hF);
      checkOutput("bp_fifo_drained", wrPtr - rdPtr, 0);
      checkOutput("bp_no_beat", beatCount, 1);
      applyStimulus(4'h9);
      waitCycles(5);
      settle();
      checkOutput("bp_tdata_stable", tdata, 16'h4321);
      checkOutput("bp_reads_stalled", wrPtr - rdPtr, 1);
      step();
      tready = 1'b1;
      settle();
      checkOutput("bp_rel_tdata0", tdata, 16'h4321);
      step();
      settle();
      checkOutput("bp_rel_tvalid1", tvalid, 1'b1);
      checkOutput("bp_rel_tdata1", tdata, 16'h8765);
      step();
      settle();
      checkOutput("bp_rel_tvalid2", tvalid, 1'b0);
      checkOutput("bp_beats", beatCount, 3);
      checkOutput("bp_beat1", beatData[1], 16'h4321);
      checkOutput("bp_beat2", beatData[2], 16'h8765);

      // Single leftover word flushed out as a one-lane beat.
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitBeats(4, "flush1_count");
      checkOutput("flush1_data", beatData[3], 16'h0009);
      checkOutput("flush1_keep", beatKeep[3], 4'b0001);

      // Partial flush of two lanes after the FIFO empties.
      applyStimulus(4'hA);
      applyStimulus(4'hB);
      waitCycles(6);
      settle();
      checkOutput("pflush_held", beatCount, 4);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitBeats(5, "pflush_count");
      checkOutput("pflush_data", beatData[4], 16'h00BA);
      checkOutput("pflush_keep", beatKeep[4], 4'b0011);

      // Flush raised while the first read is in flight: that word alone is emitted.
      step();
      applyStimulus(4'hC);
      applyStimulus(4'hD);
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitBeats(6, "inflight_count");
      checkOutput("inflight_data", beatData[5], 16'h000C);
      checkOutput("inflight_keep", beatKeep[5], 4'b0001);
      applyStimulus(4'hE);
      applyStimulus(4'hF);
      applyStimulus(4'h1);
      waitBeats(7, "after_flush_count");
      checkOutput("after_flush_data", beatData[6], 16'h1FED);
      checkOutput("after_flush_keep", beatKeep[6], 4'hF);

      // Idle flush produces no beat and does not block later reads.
      waitCycles(4);
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitCycles(8);
      settle();
      checkOutput("idle_flush_nobeat", beatCount, 7);
      checkOutput("idle_flush_tvalid", tvalid, 1'b0);
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      applyStimulus(4'h3);
      applyStimulus(4'h4);
      waitBeats(8, "idle_after_count");
      checkOutput("idle_after_data", beatData[7], 16'h4321);
      checkOutput("idle_after_keep", beatKeep[7], 4'hF);

      // Reset mid-pack discards the captured lanes.
      step();
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      waitCycles(6);
      rst = 1'b1;
      settle();
      checkOutput("midrst_ren", fifoRen, 1'b0);
      checkOutput("midrst_tvalid", tvalid, 1'b0);
      step();
      rst = 1'b0;
      applyStimulus(4'h5);
      applyStimulus(4'h6);
      applyStimulus(4'h7);
      applyStimulus(4'h8);
      waitBeats(9, "midrst_count");
      checkOutput("midrst_data", beatData[8], 16'h8765);
      checkOutput("midrst_keep", beatKeep[8], 4'hF);
      waitCycles(10);
      settle();
      checkOutput("midrst_single_beat", beatCount, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
